// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and helpers for the radix-4 Booth multiplier
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    ADD1 = 3'd1,
    ADD2 = 3'd2,
    SUB1 = 3'd3,
    SUB2 = 3'd4
  } booth_op_t;

  function automatic int booth_iters(input int width);
    return (width + 2) / 2;
  endfunction

  // Triple is {q[2i+1], q[2i], q[2i-1]} of the recoded multiplier.
  function automatic booth_op_t booth_decode(input logic [2:0] triple);
    case (triple)
      3'b001, 3'b010: return ADD1;
      3'b011:         return ADD2;
      3'b100:         return SUB2;
      3'b101, 3'b110: return SUB1;
      default:        return ZERO;
    endcase
  endfunction

endpackage

// File: rtl/booth_r4_step.sv
// rtl/booth_r4_step.sv - one combinational radix-4 Booth step: add/sub on the
// upper accumulator field, then arithmetic shift of the product register by 2.
module booth_r4_step #(
  parameter int E = 34
) (
  input  logic [2*E:0] p,
  input  logic [E-1:0] mext,
  output logic [2*E:0] p_next
);
  import mult_pkg::*;

  booth_op_t    op;
  logic [E-1:0] addend;
  logic         cin;
  logic [E-1:0] hi_sum;
  logic [2*E:0] summed;

  always_comb begin
    op     = booth_decode(p[2:0]);
    addend = '0;
    cin    = 1'b0;
    case (op)
      ADD1: addend = mext;
      ADD2: addend = {mext[E-2:0], 1'b0};
      SUB1: begin
        addend = ~mext;
        cin    = 1'b1;
      end
      SUB2: begin
        addend = ~{mext[E-2:0], 1'b0};
        cin    = 1'b1;
      end
      default: addend = '0;
    endcase
    // Accumulator wraps modulo 2^E; the final shift restores the sign.
    hi_sum = p[2*E:E+1] + addend + {{(E-1){1'b0}}, cin};
    summed = {hi_sum, p[E:0]};
    p_next = {{2{summed[2*E]}}, summed[2*E:2]};
  end

endmodule

// File: rtl/mult_booth_r4.sv
// rtl/mult_booth_r4.sv - iterative radix-4 Booth multiplier, one step per clock.
// Define MULT_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are all-equal.
module mult_booth_r4 #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               ready,
  output logic               result_valid,
  output logic [2*WIDTH-1:0] result,
  output logic               overflow
);
  import mult_pkg::*;

  localparam int E  = WIDTH + 2;
  localparam int N  = booth_iters(WIDTH);
  localparam int RW = $clog2(N + 1);

  state_t             state;
  state_t             state_next;
  logic [2*E:0]       p;
  logic [2*E:0]       p_step;
  logic [2*E:0]       p_next;
  logic [E-1:0]       mext;
  logic [E-1:0]       mext_in;
  logic [E-1:0]       qext_in;
  logic [RW-1:0]      rem;
  logic               sgn;
  logic               early_exit;
  logic               last_step;
  logic [2*WIDTH-1:0] prod;
  logic               ovf_next;

  assign mext_in = is_signed ? {{2{multiplicand[WIDTH-1]}}, multiplicand} : {2'b00, multiplicand};
  assign qext_in = is_signed ? {{2{multiplier[WIDTH-1]}}, multiplier} : {2'b00, multiplier};

  booth_r4_step #(.E(E)) u_step (
    .p      (p),
    .mext   (mext),
    .p_next (p_step)
  );

`ifdef MULT_EARLY_EXIT_EN
  logic [2*E:0] p_exit;
  logic         all_zero;
  logic         all_one;

  // P[2*rem:0] holds only the unconsumed multiplier bits; all-equal means no more adds.
  always_comb begin
    all_zero = 1'b1;
    all_one  = 1'b1;
    for (int i = 0; i <= 2*E; i++) begin
      if (i <= 2*int'(rem)) begin
        all_zero = all_zero & ~p[i];
        all_one  = all_one & p[i];
      end
    end
    early_exit = (state == RUN) && (all_zero || all_one);
    p_exit     = $signed(p) >>> (2*int'(rem));
  end

  assign p_next = early_exit ? p_exit : p_step;
`else
  assign early_exit = 1'b0;
  assign p_next     = p_step;
`endif

  assign last_step = (rem == RW'(1)) || early_exit;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign ready        = (state == IDLE) || (state == DONE);
  assign result_valid = (state == DONE);

  always_comb begin
    prod = p_next[2*WIDTH:1];
    if (sgn)
      ovf_next = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
    else
      ovf_next = |prod[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      p        <= '0;
      mext     <= '0;
      rem      <= '0;
      sgn      <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      if (ready && start) begin
        p    <= {{E{1'b0}}, qext_in, 1'b0};
        mext <= mext_in;
        rem  <= RW'(N);
        sgn  <= is_signed;
      end else if (state == RUN) begin
        p   <= p_next;
        rem <= rem - RW'(1);
        if (last_step) begin
          result   <= prod;
          overflow <= ovf_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_booth_r4.sv
// tb/tb_mult_booth_r4.sv - directed vectors against an arithmetic product/latency model.
module tb_mult_booth_r4;
  localparam int W = 32;
  localparam int E = W + 2;
  localparam int N = E / 2;
`ifdef MULT_EARLY_EXIT_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic           is_signed = 1'b0;
  logic [W-1:0]   multiplicand = '0;
  logic [W-1:0]   multiplier = '0;
  logic           ready;
  logic           result_valid;
  logic [2*W-1:0] result;
  logic           overflow;

  mult_booth_r4 #(.WIDTH(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .is_signed    (is_signed),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .ready        (ready),
    .result_valid (result_valid),
    .result       (result),
    .overflow     (overflow)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    logic        ovf;
    int          acc;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;
  int   last_lat = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic logic [63:0] model_prod(input bit sgn, input logic [W-1:0] m, input logic [W-1:0] q);
    longint sm, sq;
    longint unsigned um, uq;
    if (sgn) begin
      sm = longint'($signed(m));
      sq = longint'($signed(q));
      return 64'(sm * sq);
    end
    um = {32'b0, m};
    uq = {32'b0, q};
    return um * uq;
  endfunction

  function automatic logic model_ovf(input bit sgn, input logic [63:0] prod);
    if (sgn)
      return ($signed(prod) < -64'sd2147483648) || ($signed(prod) > 64'sd2147483647);
    return prod > 64'h00000000_FFFFFFFF;
  endfunction

  // Early exit fires once the not-yet-consumed multiplier bits are all-equal.
  function automatic int early_latency(input bit sgn, input logic [W-1:0] q);
    logic [E:0] qx, hi, mask;
    qx = {(sgn ? {2{q[W-1]}} : 2'b00), q, 1'b0};
    for (int s = 0; s < N; s++) begin
      hi   = qx >> (2*s);
      mask = {(E+1){1'b1}} >> (2*s);
      if (hi == '0 || hi == mask) return s + 1;
    end
    return N;
  endfunction

  // Called at a negedge while ready is high; returns at the next negedge.
  task automatic launch(input bit sgn, input logic [W-1:0] m, input logic [W-1:0] q);
    exp_t e;
    int   lat;
    start        = 1'b1;
    is_signed    = sgn;
    multiplicand = m;
    multiplier   = q;
    lat   = EARLY_EN ? early_latency(sgn, q) : N;
    e.res = model_prod(sgn, m, q);
    e.ovf = model_ovf(sgn, e.res);
    e.acc = cyc + 1;
    e.due = cyc + 1 + lat;
    exp_q.push_back(e);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL ready timeout: got 0, required 1");
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL completion timeout: got %0d pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_op(input string name, input bit sgn, input logic [W-1:0] m, input logic [W-1:0] q,
                        input logic [63:0] lit, input bit lit_ovf);
    wait_ready();
    launch(sgn, m, q);
    wait_done();
    check({name, " result"}, result, lit);
    check({name, " overflow"}, {63'b0, overflow}, {63'b0, lit_ovf});
  endtask

  always @(negedge clock) begin
    if (reset) begin
      if (result_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected result_valid at cycle %0d: got 1, required 0", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("model result", result, mon_e.res);
          check("model overflow", {63'b0, overflow}, {63'b0, mon_e.ovf});
          check_int("model latency", cyc - mon_e.acc, mon_e.due - mon_e.acc);
          last_lat = cyc - mon_e.acc;
        end
      end else if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
        n_vec++;
        n_bad++;
        $display("FAIL missing result_valid at cycle %0d: got 0, required 1", exp_q[0].due);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    check("pin model 7*-3", model_prod(1'b1, 32'd7, 32'hFFFFFFFD), 64'hFFFFFFFF_FFFFFFEB);
    check("pin model ffff*10001", model_prod(1'b0, 32'h0000FFFF, 32'h00010001), 64'h00000000_FFFFFFFF);

    repeat (3) @(negedge clock);
    check("reset ready", {63'b0, ready}, 64'd1);
    check("reset result_valid", {63'b0, result_valid}, 64'd0);
    check("reset result", result, 64'd0);
    check("reset overflow", {63'b0, overflow}, 64'd0);
    reset = 1'b1;
    @(negedge clock);

    run_op("s 7*-3", 1'b1, 32'd7, 32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFEB, 1'b0);
    check_int("s 7*-3 latency", last_lat, EARLY_EN ? 3 : 17);
    run_op("s min*min", 1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b1);
    run_op("u ff*ff", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b1);
    run_op("s -1*-1", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 1'b0);
    run_op("s max*2", 1'b1, 32'h7FFFFFFF, 32'd2, 64'h00000000_FFFFFFFE, 1'b1);
    run_op("s -1*min", 1'b1, 32'hFFFFFFFF, 32'h80000000, 64'h00000000_80000000, 1'b1);
    run_op("u ffff*10001", 1'b0, 32'h0000FFFF, 32'h00010001, 64'h00000000_FFFFFFFF, 1'b0);
    run_op("s 5*3", 1'b1, 32'd5, 32'd3, 64'd15, 1'b0);
    check_int("s 5*3 latency", last_lat, EARLY_EN ? 3 : 17);
    run_op("s 5*0", 1'b1, 32'd5, 32'd0, 64'd0, 1'b0);
    check_int("s 5*0 latency", last_lat, EARLY_EN ? 1 : 17);

    // start during RUN is dropped; start during DONE chains the next op
    wait_ready();
    launch(1'b0, 32'd3, 32'h55555555);
    repeat (4) @(negedge clock);
    check("ready in run", {63'b0, ready}, 64'd0);
    start = 1'b1; multiplicand = 32'd2; multiplier = 32'd2;
    @(negedge clock);
    start = 1'b0;
    for (int n = 0; n < 40 && !result_valid; n++) @(negedge clock);
    check("ignored-start result", result, 64'h00000000_FFFFFFFF);
    check("ready in done", {63'b0, ready}, 64'd1);
    launch(1'b1, 32'd5, 32'd3);
    wait_done();
    check("chained result", result, 64'd15);
    check_int("chained latency", last_lat, EARLY_EN ? 3 : 17);

    // reset in RUN cycle 8 aborts without a result
    wait_ready();
    launch(1'b0, 32'd3, 32'h55555555);
    repeat (7) @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clock);
    reset = 1'b1;
    check("abort ready", {63'b0, ready}, 64'd1);
    check("abort result_valid", {63'b0, result_valid}, 64'd0);
    check("abort result", result, 64'd0);
    check("abort overflow", {63'b0, overflow}, 64'd0);
    repeat (25) @(negedge clock);

    run_op("u 1000*1000", 1'b0, 32'd1000, 32'd1000, 64'd1000000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_booth_r4.md
# mult_booth_r4

Parametrised, iterative radix-4 Booth multiplier for the MIPS execute stage. It accepts two WIDTH-bit operands with a start pulse, runs one Booth step per clock, and returns the full 2*WIDTH-bit product. Operands can be treated as signed or unsigned, and the block flags products that do not fit in WIDTH bits. It serves the mult/multu path and the HI/LO writeback.

## Interface
- WIDTH, 32, operand width; must be even and at least 4.
- clock  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low; reset takes effect at the clock edge where reset==0.
- start  in  1  request; accepted only when ready==1.
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- multiplicand  in  WIDTH  operand M; sampled with start.
- multiplier  in  WIDTH  operand Q; sampled with start.
- ready  out  1  high in IDLE and DONE.
- result_valid  out  1  high for exactly the one DONE cycle.
- result  out  2*WIDTH  product; held until the next accepted start.
- overflow  out  1  product not representable in WIDTH bits; held with result.

## Operation
- Extended width E = WIDTH+2. On accept, M and Q are sign-extended (is_signed=1) or zero-extended (is_signed=0) to E bits.
- Iteration count N = E/2, which is 17 for WIDTH=32.
- Product register P has 2E+1 bits and loads as {E'b0, Qext, 1'b0}. A step counter rem loads N.
- FSM has three states:
  - IDLE --start--> RUN.
  - RUN --(rem==1 step done, or early exit)--> DONE.
  - DONE --start--> RUN; DONE --no start--> IDLE.
- RUN step:
  - Booth triple P[2:0] selects the operation: 000/111 = 0, 001/010 = +M, 011 = +2M, 100 = -2M, 101/110 = -M.
  - Addition is applied to P[2E:E+1], modulo 2^E. Subtraction is done as invert plus carry-in 1.
  - Then P is arithmetic-shifted right by 2 and rem decrements.
- Entering DONE:
  - result = P[2*WIDTH:1], the low 2*WIDTH bits of the product.
  - overflow (signed) = result[2*WIDTH-1:WIDTH-1] is not all-equal.
  - overflow (unsigned) = result[2*WIDTH-1:WIDTH] is nonzero.
- start in RUN is ignored; there is no queueing. start in DONE is accepted, giving back-to-back operation.
- Reset: state goes to IDLE and P, rem, result, overflow and result_valid are cleared to 0. ready=1 in the cycle after the reset edge. A reset mid-RUN aborts the operation with no result_valid.
- Output reset values: ready=1, result_valid=0, result=0, overflow=0.

## Timing
- Start accepted at edge k. RUN steps occur on edges k+1 through k+N. DONE is entered at edge k+N, so result_valid is high during cycle k+N to k+N+1. Latency is N cycles: 17 for WIDTH=32.
- result and overflow become valid in the same cycle as result_valid and stay stable until the edge after the next accepted start.
- Throughput: one operation per N cycles when start is asserted in DONE.

## Configuration
- MULT_EARLY_EXIT_EN
- Defined:
  - In each RUN cycle, if P[2*rem:0] is all-zeros or all-ones, every remaining triple is a no-op.
  - In that case P is arithmetic-shifted right by 2*rem in that cycle, with no add, and the FSM goes to DONE.
  - Latency becomes data-dependent, from 1 to N cycles. Results are bit-identical to the non-early-exit build.
- Not defined: the check is absent and latency is always N.

## Structure
- Package mult_pkg holds:
  - the state encoding (IDLE, RUN, DONE);
  - the Booth operation codes (ZERO, ADD1, ADD2, SUB1, SUB2);
  - a constant function booth_iters(WIDTH) returning (WIDTH+2)/2.
- Sub-module booth_r4_step is combinational. It takes P, Mext and the triple, and returns the next P after add/subtract and the shift by 2. Top level holds the FSM, counter, registers and early-exit logic.

## Test plan
- WIDTH=32, signed, M=7, Q=-3:
  - result=0xFFFFFFFF_FFFFFFEB, overflow=0.
  - result_valid is high exactly 17 cycles after the start edge, for one cycle.
- Signed 0x80000000 × 0x80000000: result=0x40000000_00000000, overflow=1.
- 0xFFFFFFFF × 0xFFFFFFFF:
  - Unsigned: result=0xFFFFFFFE_00000001, overflow=1.
  - Signed: result=0x00000000_00000001, overflow=0.
- start pulsed in RUN cycle 5 with new operands:
  - It is ignored; the original product is returned at cycle 17.
  - start held in the DONE cycle launches the next operation, whose result_valid comes 17 cycles later.
- reset=0 during RUN cycle 8, then released:
  - Next cycle: ready=1, result=0, overflow=0.
  - No result_valid appears for the aborted operation.
- Early exit, signed M=5, Q=3:
  - Macro defined: result=15, result_valid 3 cycles after start.
  - Macro undefined: result=15, result_valid after 17 cycles.
  - With Q=0 and the macro defined, result_valid comes after 1 cycle.
